// File: rtl/qc_ldpc_pkg.sv
// Shared definitions for the QC-LDPC datapath blocks.
//   QC_MAXZ      : default maximum lifting size (data width)
//   QC_SB_W      : width of the per-beat z / shift sideband fields (MAXZ up to 2**QC_SB_W-1)
//   qc_beat_sb_t : sideband carried with every beat through the shifter pipe
//   num_regs()   : pipeline register count for a given mux-level grouping
package qc_ldpc_pkg;

   localparam int unsigned QC_MAXZ = 81;
   localparam int unsigned QC_SB_W = 10;

   typedef struct packed {
      logic [QC_SB_W-1:0] z;
      logic [QC_SB_W-1:0] shift;
      logic               err;
      logic               dir;
   } qc_beat_sb_t;

   // ceil(levels / per_reg)
   function automatic int unsigned num_regs(input int unsigned levels,
                                            input int unsigned per_reg);
      return (levels + per_reg - 1) / per_reg;
   endfunction

endpackage

// File: rtl/zrotate_level.sv
// One combinational mux level of the z-relative rotator: when i_en is set,
// rotates i_data right by 2**LEVEL within the low i_z bits.
//   i_data : word to rotate (bits >= i_z are expected to be 0)
//   i_z    : lifting size of this beat
//   i_en   : apply this level's rotate (shift bit LEVEL)
//   o_data : rotated word; bits >= i_z are forced to 0 when enabled
module zrotate_level #(
   parameter int unsigned MAXZ  = 81,
   parameter int unsigned LEVEL = 0
) (
   input  logic [MAXZ-1:0]           i_data,
   input  logic [$clog2(MAXZ+1)-1:0] i_z,
   input  logic                      i_en,
   output logic [MAXZ-1:0]           o_data
);

   localparam int unsigned STEP = 32'd1 << LEVEL;
   localparam int unsigned IW   = (MAXZ > 1) ? $clog2(MAXZ) : 1;

   logic [31:0] z_c;
   logic [31:0] sum_c;

   // The accumulated shift stays below z, so a single wrap subtraction suffices.
   always_comb begin
      o_data = i_data;
      z_c    = 32'(i_z);
      sum_c  = '0;
      if (i_en) begin
         for (int unsigned k = 0; k < MAXZ; k++) begin
            sum_c = k + STEP;
            if (k >= z_c) begin
               o_data[k] = 1'b0;
            end else if (sum_c < z_c) begin
               o_data[k] = i_data[IW'(sum_c)];
            end else begin
               o_data[k] = i_data[IW'(sum_c - z_c)];
            end
         end
      end
   end

endmodule

// File: rtl/qc_zshift_pipe.sv
// Elastic pipelined circular shifter: rotates a MAXZ-bit word right by
// i_shift within a per-beat lifting size i_z, with valid/ready flow control.
// Optional macro QC_SHIFT_LEFT_EN adds i_dir (1 = left rotate within z).
//   CLK, rst_n       : clock, synchronous active-low reset
//   i_valid/i_ready  : input handshake (i_ready combinational from o_ready)
//   i_data/i_z/i_shift (/i_dir) : beat payload and per-beat controls
//   o_valid/o_ready  : output handshake
//   o_data, o_err    : rotated word (0 above z) and illegal-beat flag
module qc_zshift_pipe
   import qc_ldpc_pkg::*;
#(
   parameter int unsigned MAXZ           = QC_MAXZ,
   parameter int unsigned LEVELS_PER_REG = 1,
   parameter int unsigned ZW             = $clog2(MAXZ + 1),
   parameter int unsigned SW             = $clog2(MAXZ)
) (
   input  logic            CLK,
   input  logic            rst_n,
   input  logic            i_valid,
   output logic            i_ready,
   input  logic [MAXZ-1:0] i_data,
   input  logic [ZW-1:0]   i_z,
   input  logic [SW-1:0]   i_shift,
`ifdef QC_SHIFT_LEFT_EN
   input  logic            i_dir,
`endif
   output logic            o_valid,
   input  logic            o_ready,
   output logic [MAXZ-1:0] o_data,
   output logic            o_err
);

   localparam int unsigned NUM_LEVELS = $clog2(MAXZ);
   localparam int unsigned NUM_REGS   = num_regs(NUM_LEVELS, LEVELS_PER_REG);

   logic                adv_c;
   logic                err_c;
   logic [SW-1:0]       eff_shift_c;
   logic [MAXZ-1:0]     data_in_c;
   qc_beat_sb_t         sb_in_c;

   logic [NUM_REGS-1:0] vld_d;
   logic [NUM_REGS-1:0] vld_q;
   logic [MAXZ-1:0]     data_d [NUM_REGS];
   logic [MAXZ-1:0]     data_q [NUM_REGS];
   qc_beat_sb_t         sb_d   [NUM_REGS];
   qc_beat_sb_t         sb_q   [NUM_REGS];
   logic                unused_sb;

   // Global enable: every stage moves together unless the output is held.
   assign adv_c   = !o_valid || o_ready;
   assign i_ready = adv_c && rst_n;

   // Illegal beat: z out of 1..MAXZ or shift not below z.
   always_comb begin
      err_c = (i_z == '0) || (32'(i_z) > MAXZ) || (ZW'(i_shift) >= i_z);
   end

   // Left rotate by s equals right rotate by z - s (0 stays 0).
   always_comb begin
      eff_shift_c = i_shift;
`ifdef QC_SHIFT_LEFT_EN
      if (i_dir && (i_shift != '0)) begin
         eff_shift_c = SW'(i_z - ZW'(i_shift));
      end
`endif
   end

   // Mask bits at or above z; illegal beats enter as all-zero, no rotate.
   always_comb begin
      data_in_c = '0;
      for (int unsigned k = 0; k < MAXZ; k++) begin
         data_in_c[k] = (k < 32'(i_z)) && !err_c ? i_data[k] : 1'b0;
      end
   end

   always_comb begin
      sb_in_c       = '0;
      sb_in_c.z     = QC_SB_W'(i_z);
      sb_in_c.shift = err_c ? '0 : QC_SB_W'(eff_shift_c);
      sb_in_c.err   = err_c;
`ifdef QC_SHIFT_LEFT_EN
      sb_in_c.dir   = i_dir;
`endif
   end

   // Each stage applies its group of mux levels ahead of its register.
   for (genvar s = 0; s < NUM_REGS; s++) begin : g_stage
      localparam int unsigned L0 = s * LEVELS_PER_REG;
      localparam int unsigned LN = (L0 + LEVELS_PER_REG > NUM_LEVELS) ?
                                   (NUM_LEVELS - L0) : LEVELS_PER_REG;

      logic [MAXZ-1:0] chain [LN+1];
      qc_beat_sb_t     sb_c;

      if (s == 0) begin : g_first
         assign chain[0] = data_in_c;
         assign sb_c     = sb_in_c;
         assign vld_d[s] = i_valid;
      end else begin : g_rest
         assign chain[0] = data_q[s-1];
         assign sb_c     = sb_q[s-1];
         assign vld_d[s] = vld_q[s-1];
      end

      for (genvar l = 0; l < LN; l++) begin : g_lvl
         zrotate_level #(
            .MAXZ  (MAXZ),
            .LEVEL (L0 + l)
         ) u_lvl (
            .i_data (chain[l]),
            .i_z    (ZW'(sb_c.z)),
            .i_en   (sb_c.shift[L0 + l]),
            .o_data (chain[l+1])
         );
      end

      assign data_d[s] = chain[LN];
      assign sb_d[s]   = sb_c;
   end

   // Stage registers, all gated by the global enable.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < NUM_REGS; s++) begin
            vld_q[s]  <= 1'b0;
            data_q[s] <= '0;
            sb_q[s]   <= '0;
         end
      end else if (adv_c) begin
         for (int unsigned s = 0; s < NUM_REGS; s++) begin
            vld_q[s]  <= vld_d[s];
            data_q[s] <= data_d[s];
            sb_q[s]   <= sb_d[s];
         end
      end
   end

   assign o_valid = vld_q[NUM_REGS-1];
   assign o_data  = data_q[NUM_REGS-1];
   assign o_err   = sb_q[NUM_REGS-1].err;

   // Sideband fields not consumed downstream (upper z bits, last-stage z/shift/dir).
   always_comb begin
      unused_sb = 1'b0;
      for (int unsigned s = 0; s < NUM_REGS; s++) begin
         unused_sb = unused_sb ^ (^sb_q[s]);
      end
   end

endmodule

// File: tb/tb_qc_zshift_pipe.sv
// Scoreboard bench for qc_zshift_pipe: directed vectors with hand-computed
// results, a pseudo-random mixed-z burst with a 3-cycle output stall, a
// mid-stream reset, and a LEVELS_PER_REG=3 instance for latency.
module tb_qc_zshift_pipe;

   localparam int MZ   = 81;
   localparam int ZW   = 7;
   localparam int SW   = 7;
   localparam int NREG = 7;

   typedef struct {
      logic [MZ-1:0] d;
      logic          e;
      int            cyc;
      bit            lat;
   } exp_t;

   logic          CLK;
   logic          rst_n;
   logic          i_valid, i_ready;
   logic [MZ-1:0] i_data;
   logic [ZW-1:0] i_z;
   logic [SW-1:0] i_shift;
`ifdef QC_SHIFT_LEFT_EN
   logic          i_dir;
`endif
   logic          o_valid, o_ready, o_err;
   logic [MZ-1:0] o_data;

   logic          i_valid3, i_ready3, o_valid3, o_ready3, o_err3;
   logic [MZ-1:0] o_data3;

   exp_t sbq[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   qc_zshift_pipe dut (
      .CLK     (CLK),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_data  (i_data),
      .i_z     (i_z),
      .i_shift (i_shift),
`ifdef QC_SHIFT_LEFT_EN
      .i_dir   (i_dir),
`endif
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_err   (o_err)
   );

   qc_zshift_pipe #(.LEVELS_PER_REG(3)) dut3 (
      .CLK     (CLK),
      .rst_n   (rst_n),
      .i_valid (i_valid3),
      .i_ready (i_ready3),
      .i_data  (i_data),
      .i_z     (i_z),
      .i_shift (i_shift),
`ifdef QC_SHIFT_LEFT_EN
      .i_dir   (i_dir),
`endif
      .o_valid (o_valid3),
      .o_ready (o_ready3),
      .o_data  (o_data3),
      .o_err   (o_err3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [MZ-1:0] act, input logic [MZ-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Reference rotate straight from the definition.
   function automatic logic [MZ-1:0] model(input logic [MZ-1:0] d, input int z,
                                           input int sh, input bit dir);
      logic [MZ-1:0] r;
      r = '0;
      for (int k = 0; k < z; k++) begin
         r[k] = dir ? d[(k - sh + z) % z] : d[(k + sh) % z];
      end
      return r;
   endfunction

   // Drive one beat at the negedge; record the expectation once it will be taken.
   task automatic send(input logic [MZ-1:0] d, input int z, input int sh, input bit dir,
                       input logic [MZ-1:0] exp_d, input bit exp_e, input bit lat);
      int   n;
      exp_t e;
      @(negedge CLK);
      i_valid = 1'b1;
      i_data  = d;
      i_z     = ZW'(z);
      i_shift = SW'(sh);
`ifdef QC_SHIFT_LEFT_EN
      i_dir   = dir;
`endif
      n = 0;
      while (!i_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (!i_ready) begin
         chk("accept_timeout", 81'(i_ready), 81'(1));
      end else begin
         e.d = exp_d; e.e = exp_e; e.cyc = cyc; e.lat = lat;
         sbq.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge CLK);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(posedge CLK);
         n++;
      end
      @(negedge CLK);
      chk("drain_empty", 81'(sbq.size()), 81'(0));
   endtask

   // Monitor: pops on every output transfer and checks hold during stalls.
   initial begin : monitor
      bit            prev_stall;
      logic [MZ-1:0] prev_data;
      logic          prev_err;
      exp_t          e;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_err   = 1'b0;
      forever begin
         @(posedge CLK);
         #4;
         if (prev_stall) begin
            chk("stall_valid", 81'(o_valid), 81'(1));
            chk("stall_data", o_data, prev_data);
            chk("stall_err", 81'(o_err), 81'(prev_err));
         end
         if (o_valid && o_ready) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_beat: got data %h, required no beat", o_data);
            end else begin
               e = sbq.pop_front();
               chk("data", o_data, e.d);
               chk("err", 81'(o_err), 81'(e.e));
               if (e.lat) chk("latency", 81'(cyc - e.cyc), 81'(NREG));
            end
         end
         prev_stall = o_valid && !o_ready;
         prev_data  = o_data;
         prev_err   = o_err;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish, required finish before timeout");
      $fatal(1, "watchdog");
   end

   localparam int ZTAB[8] = '{81, 24, 1, 2, 40, 7, 64, 80};

   initial begin : stim
      logic [MZ-1:0] d, ex;
      int            z, sh, n, c0;
      bit            dir;
      rst_n = 1'b0; i_valid = 1'b0; i_valid3 = 1'b0;
      i_data = '0; i_z = '0; i_shift = '0;
`ifdef QC_SHIFT_LEFT_EN
      i_dir = 1'b0;
`endif
      o_ready = 1'b1; o_ready3 = 1'b1;

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_o_valid", 81'(o_valid), 81'(0));
      chk("rst_o_data", o_data, '0);
      chk("rst_o_err", 81'(o_err), 81'(0));
      chk("rst_i_ready", 81'(i_ready), 81'(0));
      chk("rst_o_valid3", 81'(o_valid3), 81'(0));
      rst_n = 1'b1;
      #1 chk("post_rst_i_ready", 81'(i_ready), 81'(1));

      // Directed, back to back, with hand-computed results
      d = '0; d[0] = 1'b1; ex = '0; ex[80] = 1'b1;
      send(d, 81, 1, 0, ex, 0, 1);
      d = '0; d[3] = 1'b1; d[50] = 1'b1; ex = '0; ex[22] = 1'b1;
      send(d, 24, 5, 0, ex, 0, 1);
      d = {MZ{1'b1}};
      send(d, 24, 24, 0, '0, 1, 1);
      d = '0; d[0] = 1'b1; ex = '0; ex[1] = 1'b1;
      send(d, 24, 23, 0, ex, 0, 1);
      d = {MZ{1'b1}}; ex = '0; ex[0] = 1'b1;
      send(d, 1, 0, 0, ex, 0, 1);
      send({MZ{1'b1}}, 0, 0, 0, '0, 1, 1);
      send({MZ{1'b1}}, 82, 0, 0, '0, 1, 1);
      d = '0; d[80] = 1'b1; ex = '0; ex[0] = 1'b1;
      send(d, 81, 80, 0, ex, 0, 1);
      send({MZ{1'b1}}, 81, 0, 0, {MZ{1'b1}}, 0, 1);
`ifdef QC_SHIFT_LEFT_EN
      d = '0; d[3] = 1'b1; ex = '0; ex[8] = 1'b1;
      send(d, 24, 5, 1, ex, 0, 1);
      d = '0; d[9] = 1'b1; ex = '0; ex[9] = 1'b1;
      send(d, 24, 0, 1, ex, 0, 1);
`endif
      idle();
      drain();

      // LEVELS_PER_REG = 3: three stages
      @(negedge CLK);
      d = '0; d[0] = 1'b1; i_data = d; i_z = ZW'(81); i_shift = SW'(1);
      i_valid3 = 1'b1;
      chk("lpr3_ready", 81'(i_ready3), 81'(1));
      c0 = cyc;
      @(negedge CLK);
      i_valid3 = 1'b0;
      n = 0;
      do begin
         @(posedge CLK);
         #4;
         n++;
      end while (!o_valid3 && n < 20);
      ex = '0; ex[80] = 1'b1;
      chk("lpr3_valid", 81'(o_valid3), 81'(1));
      chk("lpr3_latency", 81'(cyc - c0), 81'(3));
      chk("lpr3_data", o_data3, ex);
      chk("lpr3_err", 81'(o_err3), 81'(0));

      // Mixed-z burst with o_ready low for cycles 9..11
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               z   = ZTAB[$urandom_range(0, 7)];
               sh  = $urandom_range(0, z - 1);
               d   = MZ'({$urandom, $urandom, $urandom});
`ifdef QC_SHIFT_LEFT_EN
               dir = 1'($urandom_range(0, 1));
`else
               dir = 1'b0;
`endif
               send(d, z, sh, dir, model(d, z, sh, dir), 0, 0);
            end
            idle();
         end
         begin
            repeat (9) @(posedge CLK);
            #2 o_ready = 1'b0;
            repeat (3) @(posedge CLK);
            #2 o_ready = 1'b1;
         end
      join
      drain();

      // Mid-stream reset: in-flight beats vanish
      for (int i = 0; i < 4; i++) begin
         d = MZ'({$urandom, $urandom, $urandom});
         send(d, 40, i, 0, model(d, 40, i, 0), 0, 0);
      end
      @(negedge CLK);
      i_valid = 1'b0;
      rst_n   = 1'b0;
      sbq.delete();
      #1 chk("midrst_i_ready", 81'(i_ready), 81'(0));
      @(negedge CLK);
      rst_n = 1'b1;
      chk("midrst_o_valid", 81'(o_valid), 81'(0));
      repeat (12) @(posedge CLK);
      d = '0; d[5] = 1'b1; ex = '0; ex[2] = 1'b1;
      send(d, 17, 3, 0, ex, 0, 1);
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
